seq_detector_param: RTL and testbench

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_det_sat_cnt.sv | 23 ++
 rtl/seq_detector_param.sv | 124 ++++++++++++
 tb/tb_seq_detector_param.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parameterised serial
// pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SCAN,
    HIT
  } state_e;

  localparam logic [31:0] RST_PATTERN_DEF = 32'h0000_0015;
  localparam int          RST_LEN_DEF     = 5;
  localparam logic        RST_OVERLAP_DEF = 1'b1;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter; a clear coincident with an
// increment leaves the count at one.
module seq_det_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= W'(inc);
    end else if (inc && count != '1) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with
// overlap control and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(RST_PATTERN_DEF),
  parameter int               RST_LEN     = RST_LEN_DEF,
  parameter logic             RST_OVERLAP = RST_OVERLAP_DEF,
  localparam int              LEN_W       = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ip_valid,
  input  logic             ip,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             op,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);

  state_e           state, state_nx;
  logic [PAT_W-1:0] hist, hist_nx, hist_sh;
  logic [PAT_W-1:0] pat, pat_nx, mask;
  logic [LEN_W-1:0] fill, fill_nx, fill_inc;
  logic [LEN_W-1:0] len, len_nx;
  logic             ovl, ovl_nx;
  logic             err_nx, consume, match, len_ok;

  function automatic state_e rest_state(
    input logic [LEN_W-1:0] f,
    input logic [LEN_W-1:0] l
  );
    if (f == '0)   return IDLE;
    else if (f < l) return FILL;
    else           return SCAN;
  endfunction

  always_comb begin
    hist_sh  = {hist[PAT_W-2:0], ip};
    fill_inc = (fill == FULL) ? fill : fill + LEN_W'(1);
    mask     = ~({PAT_W{1'b1}} << len);
    consume  = ip_valid & ~cfg_load;
    match    = consume && (fill_inc >= len) &&
               (((hist_sh ^ pat) & mask) == '0);
    len_ok   = (cfg_len != '0) && (cfg_len <= FULL);
  end

  // Bits are discarded while a load is presented, accepted or not.
  always_comb begin
    state_nx = rest_state(fill, len);
    hist_nx  = hist;
    fill_nx  = fill;
    pat_nx   = pat;
    len_nx   = len;
    ovl_nx   = ovl;
    err_nx   = 1'b0;
    unique case (1'b1)
      cfg_load: begin
        if (len_ok) begin
          pat_nx   = cfg_pattern;
          len_nx   = cfg_len;
          ovl_nx   = cfg_overlap;
          hist_nx  = '0;
          fill_nx  = '0;
          state_nx = IDLE;
        end else begin
          err_nx = 1'b1;
        end
      end
      consume: begin
        hist_nx = hist_sh;
        if (match) begin
          state_nx = HIT;
          fill_nx  = ovl ? fill_inc : '0;
        end else begin
          fill_nx  = fill_inc;
          state_nx = rest_state(fill_inc, len);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      hist    <= '0;
      fill    <= '0;
      pat     <= RST_PATTERN;
      len     <= LEN_W'(RST_LEN);
      ovl     <= RST_OVERLAP;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nx;
      hist    <= hist_nx;
      fill    <= fill_nx;
      pat     <= pat_nx;
      len     <= len_nx;
      ovl     <= ovl_nx;
      cfg_err <= err_nx;
    end
  end

  assign op = (state == HIT);

  seq_det_sat_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (cnt_clr),
    .count(match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param
// against a bit-queue reference model.
module tb_seq_detector_param;
  import seq_det_pkg::*;

  localparam int PW = 8;
  localparam int LW = $clog2(PW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, ip_valid, ip, cfg_load;
  logic          cfg_overlap, cnt_clr;
  logic [PW-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          op, cfg_err, op2, cfg_err2;
  logic [15:0]   mc;
  logic [1:0]    mc2;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .ip_valid(ip_valid), .ip(ip),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .op(op), .match_count(mc),
    .cfg_err(cfg_err)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .ip_valid(ip_valid), .ip(ip),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .op(op2), .match_count(mc2),
    .cfg_err(cfg_err2)
  );

  int vectors = 0;
  int errors  = 0;

  // reference model: bits consumed since the last fill clear
  bit            q[$];
  logic [PW-1:0] m_pat;
  int            m_len;
  bit            m_ovl;
  int            m_cnt, m_cnt2;
  bit            e_op, e_err, hit;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_in();
    reset = 0; ip_valid = 0; ip = 0; cfg_load = 0;
    cfg_overlap = 0; cnt_clr = 0; cfg_pattern = '0; cfg_len = '0;
  endtask

  task automatic cyc();
    e_op = 0; e_err = 0; hit = 0;
    if (reset) begin
      m_pat = PW'(RST_PATTERN_DEF);
      m_len = RST_LEN_DEF;
      m_ovl = RST_OVERLAP_DEF;
      q.delete();
      m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (cfg_load) begin
        if (cfg_len >= 1 && int'(cfg_len) <= PW) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len);
          m_ovl = cfg_overlap; q.delete();
        end else begin
          e_err = 1;
        end
      end else if (ip_valid) begin
        q.push_back(ip);
        if (q.size() > PW) void'(q.pop_front());
        if (q.size() >= m_len) begin
          hit = 1;
          for (int i = 0; i < m_len; i++)
            if (q[q.size() - m_len + i] != m_pat[m_len-1-i]) hit = 0;
        end
        if (hit && !m_ovl) q.delete();
      end
      e_op = hit;
      if (cnt_clr) begin
        m_cnt = int'(hit); m_cnt2 = int'(hit);
      end else if (hit) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
    chk("op", op, e_op);
    chk("cfg_err", cfg_err, e_err);
    chk("count", mc, 32'(m_cnt));
    chk("op_w2", op2, e_op);
    chk("count_w2", mc2, 32'(m_cnt2));
  endtask

  task automatic do_reset();
    clr_in(); reset = 1; cyc(); reset = 0;
  endtask

  task automatic idle(input int n);
    clr_in();
    repeat (n) cyc();
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      clr_in(); ip_valid = 1; ip = bits[i]; cyc();
    end
    clr_in();
  endtask

  task automatic load(input logic [PW-1:0] p, input int l,
                      input bit o);
    clr_in(); cfg_load = 1; cfg_pattern = p;
    cfg_len = LW'(l); cfg_overlap = o; cyc(); clr_in();
  endtask

  initial begin
    clr_in();
    do_reset();
    chk("rst_op", op, 0);
    chk("rst_cnt", mc, 0);

    send(32'b1010101, 7);
    chk("dflt_cnt", mc, 2);

    load(8'b110, 3, 0);
    send(32'b110110, 6);
    load(8'b11, 2, 1);
    send(32'b111, 3);

    load(8'b10101, 5, 0);
    send(32'b101010101, 9);
    send(32'b10101, 5);

    load(8'b10101, 5, 1);
    for (int i = 4; i >= 0; i--) begin
      send(32'(i % 2 == 0), 1);
      idle(3);
    end

    load(8'b1001, 4, 1);
    load(8'hff, 0, 0);
    load(8'hff, PW + 1, 0);
    send(32'b1001001, 7);
    send(32'b100, 3);
    clr_in(); ip_valid = 1; ip = 1; cfg_load = 1;
    cfg_pattern = 8'b1001; cfg_len = 4; cfg_overlap = 1;
    cyc();
    chk("load_vs_bit", op, 0);
    clr_in();

    do_reset();
    send(32'b1010101010101, 13);
    chk("sat_w2", mc2, 3);
    send(32'b1010, 4);
    clr_in(); ip_valid = 1; ip = 1; cnt_clr = 1; cyc();
    chk("clr_hit", mc, 1);
    clr_in(); cnt_clr = 1; cyc();
    chk("clr_only", mc, 0);
    send(32'b1010, 4);
    do_reset();
    send(32'b1, 1);
    chk("rst_abort", op, 0);

    repeat (3000) begin
      int r;
      clr_in();
      r = int'($urandom_range(0, 199));
      reset = (r == 0);
      cfg_load = (r >= 1 && r <= 6);
      cfg_pattern = PW'($urandom);
      cfg_len = ($urandom_range(0, 4) == 0) ?
                LW'($urandom_range(0, 9)) : LW'($urandom_range(1, 4));
      cfg_overlap = 1'($urandom_range(0, 1));
      ip_valid = ($urandom_range(0, 3) != 0);
      ip = 1'($urandom_range(0, 1));
      cnt_clr = ($urandom_range(0, 59) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
